svm_mem_mngr: RTL
=================

# svm_mem_mngr

Memory-manager stage directly upstream of the SVM weight/data-vector register array. On a start request it fetches `num_dim` consecutive words from the parameter/sample memory into a small show-ahead FIFO. The FIFO head drives the array's `mem_mngr_data`/`mem_mngr_data_vld` inputs, and the array's `pop_fifo` consumes one word per cycle. Credit-based flow control means the FIFO never overflows, whatever the memory read latency.

## Interface
Parameters:
- DATA_WIDTH, 32, word width (IEEE-754 single).
- ADDR_WIDTH, 16, memory word-address width.
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥ 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a fetch.
- start_base_addr  in  ADDR_WIDTH  first word address.
- start_num_dim  in  6  words to fetch; values > 32 clamp to 32.
- flush  in  1  abort the fetch and empty the FIFO.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse: all words delivered and popped.
- mem_rd_en  out  1  read request, one word per cycle.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  DATA_WIDTH  returned word.
- mem_rd_data_vld  in  1  return strobe; responses arrive in order, with any latency ≥ 1.
- mem_mngr_data  out  DATA_WIDTH  FIFO head.
- mem_mngr_data_vld  out  1  FIFO not empty.
- pop_fifo  in  1  consume the head this cycle.

## Operation
- States:
  - IDLE.
  - FETCH: issuing reads.
  - DRAIN: all reads issued; waiting for returns and pops.
- IDLE:
  - start with clamped num_dim > 0: latch the base address and num_dim, clear issue_cnt and deliver_cnt, go to FETCH.
  - start with num_dim = 0: pulse done the next cycle and stay in IDLE.
- FETCH:
  - Assert mem_rd_en when issue_cnt < num_dim and fifo_count + inflight < FIFO_DEPTH.
  - mem_rd_addr = base + issue_cnt, modulo 2^ADDR_WIDTH (the address wraps).
  - Go to DRAIN on the cycle the last read issues.
- inflight counter:
  - Increments on mem_rd_en.
  - Decrements on mem_rd_data_vld.
  - Unchanged when both happen in the same cycle.
- mem_rd_data_vld: pushes mem_rd_data into the FIFO.
- pop_fifo:
  - Effective only when mem_mngr_data_vld is high.
  - Increments deliver_cnt.
  - pop_fifo while empty is ignored.
- Push and pop in the same cycle: fifo_count unchanged; a full FIFO may still push if it pops that cycle.
- DRAIN: when inflight = 0, fifo_count = 0 and deliver_cnt = num_dim, pulse done and go to IDLE.
- start while busy is ignored.
- flush (any state, highest priority after rst):
  - Go to IDLE, empty the FIFO, clear issue_cnt.
  - Move inflight into discard_cnt; returns arriving after the flush decrement discard_cnt and are not pushed.
  - done is not pulsed.
  - start is refused until discard_cnt = 0.
- flush and start in the same cycle: flush wins and start is dropped.

## Timing
- Reset values:
  - Outputs: busy 0, done 0, mem_rd_en 0, mem_rd_addr 0, mem_mngr_data_vld 0, mem_mngr_data 0.
  - Internal: all counters 0, state IDLE.
- start at cycle T: first mem_rd_en at T+1.
- mem_rd_data_vld at cycle R: mem_mngr_data_vld high at R+1.
- Head data is registered and stable while vld is high and no pop occurs.
- Steady-state throughput is one word per cycle when FIFO_DEPTH ≥ read latency + 2; otherwise reads stall on credit, with no loss.
- done asserts the cycle after the final pop (or the final return, if that is later) and lasts one cycle; busy falls in that same cycle.

## Structure
- Package svm_pkg:
  - DATA_WIDTH and ADDR_WIDTH constants.
  - MAX_DIM = 32.
  - typedef enum mem_mngr_state_e {IDLE, FETCH, DRAIN}.
- Sub-module svm_sync_fifo:
  - Parameters: DATA_WIDTH, DEPTH.
  - Show-ahead, with push, pop, flush, count, empty and full.
- Top level holds the FSM and the issue, inflight, deliver and discard counters.

## Test plan
- Base 0x0100, num_dim 4, latency 2, pop_fifo tied to vld:
  - Reads issue at addresses 0x100–0x103 on consecutive cycles.
  - Four words are delivered in order; done pulses once.
- num_dim 32, FIFO_DEPTH 8, latency 6, pop held low for 20 cycles then released:
  - mem_rd_en stops once fifo_count + inflight = 8.
  - No word is lost; 32 words delivered; done pulses once.
- start_num_dim 0: done pulses at T+1, mem_rd_en is never asserted, busy stays 0.
- start_num_dim 45: clamps to 32; exactly 32 reads issue.
- Base 0xFFFE, num_dim 4: addresses FFFE, FFFF, 0000, 0001.
- flush with 3 reads in flight, followed immediately by start:
  - The 3 late returns are discarded; start is refused until discard_cnt = 0.
  - The next fetch delivers only its own data.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared constants and types for the SVM memory-manager slice.
package svm_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = 32;
  localparam int DIM_WIDTH  = 6;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} mem_mngr_state_e;
endpackage

// File: rtl/svm_mem_mngr_if.sv
// Control, memory-read and array-side signals of the memory manager.
// master = memory manager, slave = its environment (sequencer, memory, array).
interface svm_mem_mngr_if #(
  parameter int DATA_WIDTH = svm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = svm_pkg::ADDR_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_base_addr;
  logic [5:0]            start_num_dim;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_data_vld;
  logic [DATA_WIDTH-1:0] mem_mngr_data;
  logic                  mem_mngr_data_vld;
  logic                  pop_fifo;

  modport master (
    input  start, start_base_addr, start_num_dim, flush,
    output busy, done,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data, mem_rd_data_vld,
    output mem_mngr_data, mem_mngr_data_vld,
    input  pop_fifo
  );

  modport slave (
    output start, start_base_addr, start_num_dim, flush,
    input  busy, done,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data, mem_rd_data_vld,
    input  mem_mngr_data, mem_mngr_data_vld,
    output pop_fifo
  );
endinterface

// File: rtl/svm_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible whenever not empty.
module svm_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_pop;

  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // Storage is not reset, so the head is forced to zero while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array carries no reset; valid words are tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; flush discards every stored word.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/svm_mem_mngr.sv
// Fetches num_dim consecutive words into a show-ahead FIFO feeding the SVM
// register array; credits (fifo_count + inflight) keep the FIFO from overflowing.
module svm_mem_mngr
  import svm_pkg::*;
#(
  parameter int DATA_WIDTH = svm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = svm_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  svm_mem_mngr_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mem_mngr_state_e       state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DIM_WIDTH-1:0]  num_dim, issue_cnt, deliver_cnt;
  logic [CW-1:0]         inflight, discard_cnt, fifo_count;
  logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic                  norm_ret, disc_ret;
  logic [DIM_WIDTH-1:0]  clamped_dim, issue_nxt, deliver_nxt;
  logic [CW-1:0]         inflight_nxt, count_nxt;
  logic [CW:0]           credit_used;
  logic                  credit_ok;

  svm_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (bus.flush),
    .wr_data (bus.mem_rd_data),
    .rd_data (bus.mem_mngr_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bus.mem_mngr_data_vld = !fifo_empty;

  // Return routing and the post-edge counter values that the registered outputs are computed from.
  // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    clamped_dim  = (bus.start_num_dim > DIM_WIDTH'(MAX_DIM)) ? DIM_WIDTH'(MAX_DIM) : bus.start_num_dim;
    disc_ret     = bus.mem_rd_data_vld && (discard_cnt != '0);
    norm_ret     = bus.mem_rd_data_vld && (discard_cnt == '0);
    fifo_pop     = bus.pop_fifo && !fifo_empty;
    fifo_push    = norm_ret && (!fifo_full || fifo_pop);
    issue_nxt    = issue_cnt + DIM_WIDTH'(bus.mem_rd_en);
    deliver_nxt  = deliver_cnt + DIM_WIDTH'(fifo_pop);
    inflight_nxt = inflight + CW'(bus.mem_rd_en) - CW'(norm_ret);
    count_nxt    = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    credit_used  = {1'b0, count_nxt} + {1'b0, inflight_nxt};
    credit_ok    = credit_used < (CW+1)'(FIFO_DEPTH);
  end

  // Fetch FSM with registered busy/done/read outputs and the issue/inflight/deliver/discard counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base_addr       <= '0;
      num_dim         <= '0;
      issue_cnt       <= '0;
      deliver_cnt     <= '0;
      inflight        <= '0;
      discard_cnt     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= '0;
    end else if (bus.flush) begin
      // Outstanding reads become discards; their returns must never reach the FIFO.
      state         <= IDLE;
      issue_cnt     <= '0;
      inflight      <= '0;
      discard_cnt   <= discard_cnt - CW'(disc_ret) + inflight_nxt;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_rd_en <= 1'b0;
    end else begin
      bus.done        <= 1'b0;
      inflight        <= inflight_nxt;
      issue_cnt       <= issue_nxt;
      deliver_cnt     <= deliver_nxt;
      bus.mem_rd_addr <= base_addr + ADDR_WIDTH'(issue_nxt);
      if (disc_ret) discard_cnt <= discard_cnt - CW'(1);
      case (state)
        IDLE: begin
          bus.mem_rd_en <= 1'b0;
          if (bus.start && (discard_cnt == '0)) begin
            if (clamped_dim == '0) begin
              bus.done <= 1'b1;
            end else begin
              state           <= FETCH;
              bus.busy        <= 1'b1;
              base_addr       <= bus.start_base_addr;
              num_dim         <= clamped_dim;
              issue_cnt       <= '0;
              deliver_cnt     <= '0;
              bus.mem_rd_en   <= 1'b1;
              bus.mem_rd_addr <= bus.start_base_addr;
            end
          end
        end
        FETCH: begin
          if (bus.mem_rd_en && (issue_nxt == num_dim)) begin
            state         <= DRAIN;
            bus.mem_rd_en <= 1'b0;
          end else begin
            bus.mem_rd_en <= (issue_nxt < num_dim) && credit_ok;
          end
        end
        DRAIN: begin
          bus.mem_rd_en <= 1'b0;
          if ((inflight_nxt == '0) && (count_nxt == '0) && (deliver_nxt == num_dim)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
